// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller.
//   - Controller state encoding. ST_HALT exists only when HACK_CPU_STRICT_EN
//     is defined.
//   - Instruction field bit positions.
//   - Named comp-field opcodes.
//   - Jump-condition helper.
package hack_pkg;

  localparam int HACK_W    = 16;
  localparam int HACK_PC_W = 15;

  // Instruction field positions (C-instruction: 111a cccc ccdd djjj)
  localparam int C_BIT      = 15;
  localparam int A_BIT      = 12;
  localparam int COMP_HI    = 11;
  localparam int COMP_LO    = 6;
  localparam int DEST_A_BIT = 5;   // d1
  localparam int DEST_D_BIT = 4;   // d2
  localparam int DEST_M_BIT = 3;   // d3
  localparam int JUMP_HI    = 2;
  localparam int JUMP_LO    = 0;

  // Comp-field opcodes
  localparam logic [5:0] COMP_D_PLUS_A = 6'b000010;
  localparam logic [5:0] COMP_ZERO     = 6'b101010;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM_WR = 3'd4
`ifdef HACK_CPU_STRICT_EN
    , ST_HALT = 3'd5
`endif
  } state_t;

  // Jump resolution from the j-bits and the ALU flags.
  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Fetch and data-memory bus of the Hack CPU controller.
// Signals:
//   pc, instr, instr_valid                 instruction ROM fetch
//   mem_req, mem_we, mem_addr, mem_wdata   data RAM request
//   mem_rdata, mem_ack                     data RAM response
// Modports:
//   master  CPU side
//   slave   memory side
interface hack_cpu_ctrl_if import hack_pkg::*; #(
  parameter int W    = HACK_W,
  parameter int PC_W = HACK_PC_W
);
  logic [PC_W-1:0] pc;
  logic [W-1:0]    instr;
  logic            instr_valid;
  logic            mem_req;
  logic            mem_we;
  logic [PC_W-1:0] mem_addr;
  logic [W-1:0]    mem_wdata;
  logic [W-1:0]    mem_rdata;
  logic            mem_ack;

  modport master (
    output pc,
    input  instr, instr_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  pc,
    output instr, instr_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/hack_cpu_ctrl_alu.sv
// Hack ALU (module alu), purely combinational.
// Ports:
//   x, y              16-bit operands
//   zx, nx, zy, ny,   control bits
//   f, no
//   out               result
//   zr                result is zero
//   ng                result is negative
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x1_s, x2_s, y1_s, y2_s, r_s, o_s;

  // Operand preset/negate, add-or-and, output negate, flags.
  always_comb begin
    x1_s = zx ? 16'h0000 : x;
    x2_s = nx ? ~x1_s : x1_s;
    y1_s = zy ? 16'h0000 : y;
    y2_s = ny ? ~y1_s : y1_s;
    r_s  = f ? (x2_s + y2_s) : (x2_s & y2_s);
    o_s  = no ? ~r_s : r_s;
    out  = o_s;
    zr   = (o_s == 16'h0000);
    ng   = o_s[15];
  end
endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller.
//   - Owns the A, D and PC registers.
//   - Fetches instructions over bus (valid handshake).
//   - Reads/writes data memory over bus (req/ack handshake).
//   - Drives the alu with x=D and y=A or MDR, plus the six comp bits.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   bus             hack_cpu_ctrl_if.master
//                     pc, instr, instr_valid,
//                     mem_req, mem_we, mem_addr, mem_wdata,
//                     mem_rdata, mem_ack
//   a_reg, d_reg    A and D registers, for observability
//   illegal         only with HACK_CPU_STRICT_EN; high while halted
// Build option HACK_CPU_STRICT_EN:
//   A C-instruction whose bits [14:13] are not 2'b11 halts the core until
//   reset. Without the option those bits are ignored.
module hack_cpu_ctrl import hack_pkg::*; #(
  parameter int W    = HACK_W,
  parameter int PC_W = HACK_PC_W
) (
  input  logic          clk,
  input  logic          reset,
  hack_cpu_ctrl_if.master bus,
  output logic [W-1:0]  a_reg,
  output logic [W-1:0]  d_reg
`ifdef HACK_CPU_STRICT_EN
  , output logic        illegal
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [W-1:0]    a_r, a_s;
  logic [W-1:0]    d_r, d_s;
  logic [W-1:0]    ir_r, ir_s;
  logic [W-1:0]    mdr_r, mdr_s;
  logic [W-1:0]    wdr_r, wdr_s;
  logic            mem_req_r, mem_req_s;
  logic            mem_we_r, mem_we_s;

  logic [5:0]      comp_s;
  logic [W-1:0]    alu_y_s;
  logic [W-1:0]    alu_out_s;
  logic            zr_s, ng_s, jmp_s;
  logic [W-1:0]    commit_a_s, commit_d_s;
  logic [PC_W-1:0] commit_pc_s;

  // ALU operand and control selection from the held instruction.
  always_comb begin
    comp_s  = ir_r[COMP_HI:COMP_LO];
    alu_y_s = ir_r[A_BIT] ? mdr_r : a_r;
  end

  alu u_alu (
    .x   (d_r),
    .y   (alu_y_s),
    .zx  (comp_s[5]),
    .nx  (comp_s[4]),
    .zy  (comp_s[3]),
    .ny  (comp_s[2]),
    .f   (comp_s[1]),
    .no  (comp_s[0]),
    .out (alu_out_s),
    .zr  (zr_s),
    .ng  (ng_s)
  );

  // Register values a C-instruction retires with.
  // D, A and MDR stay put between EXEC and the MEM_WR ack, so the live ALU
  // result and flags are still those of the instruction. a_r here is the
  // pre-instruction A, which the jump target must use.
  always_comb begin
    jmp_s       = jump_taken(ir_r[JUMP_HI:JUMP_LO], zr_s, ng_s);
    commit_a_s  = ir_r[DEST_A_BIT] ? alu_out_s : a_r;
    commit_d_s  = ir_r[DEST_D_BIT] ? alu_out_s : d_r;
    commit_pc_s = jmp_s ? a_r[PC_W-1:0] : (pc_r + PC_ONE);
  end

  // Next-state and next-register logic of the controller FSM.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    a_s     = a_r;
    d_s     = d_r;
    ir_s    = ir_r;
    mdr_s   = mdr_r;
    wdr_s   = wdr_r;
    case (state_r)
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_s    = bus.instr;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (!ir_r[C_BIT]) begin
          a_s     = ir_r;
          pc_s    = pc_r + PC_ONE;
          state_s = ST_FETCH;
        end
`ifdef HACK_CPU_STRICT_EN
        else if (ir_r[14:13] != 2'b11) begin
          state_s = ST_HALT;
        end
`endif
        else if (ir_r[A_BIT]) begin
          state_s = ST_MEM_RD;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_MEM_RD: begin
        if (bus.mem_ack) begin
          mdr_s   = bus.mem_rdata;
          state_s = ST_EXEC;
        end else begin
          state_s = ST_MEM_RD;
        end
      end
      ST_EXEC: begin
        if (ir_r[DEST_M_BIT]) begin
          // Memory write first. A/D/PC retire on the write ack.
          wdr_s   = alu_out_s;
          state_s = ST_MEM_WR;
        end else begin
          a_s     = commit_a_s;
          d_s     = commit_d_s;
          pc_s    = commit_pc_s;
          state_s = ST_FETCH;
        end
      end
      ST_MEM_WR: begin
        if (bus.mem_ack) begin
          a_s     = commit_a_s;
          d_s     = commit_d_s;
          pc_s    = commit_pc_s;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_MEM_WR;
        end
      end
`ifdef HACK_CPU_STRICT_EN
      ST_HALT: begin
        state_s = ST_HALT;
      end
`endif
      default: begin
        state_s = ST_FETCH;
      end
    endcase
    // Request strobes are registered copies of the state being entered.
    mem_req_s = (state_s == ST_MEM_RD) || (state_s == ST_MEM_WR);
    mem_we_s  = (state_s == ST_MEM_WR);
  end

  // State and architectural registers. Async reset drops mem_req at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_FETCH;
      pc_r      <= {PC_W{1'b0}};
      a_r       <= {W{1'b0}};
      d_r       <= {W{1'b0}};
      ir_r      <= {W{1'b0}};
      mdr_r     <= {W{1'b0}};
      wdr_r     <= {W{1'b0}};
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      a_r       <= a_s;
      d_r       <= d_s;
      ir_r      <= ir_s;
      mdr_r     <= mdr_s;
      wdr_r     <= wdr_s;
      mem_req_r <= mem_req_s;
      mem_we_r  <= mem_we_s;
    end
  end

`ifdef HACK_CPU_STRICT_EN
  logic illegal_r;

  // Halt indicator, registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= (state_s == ST_HALT);
    end
  end

  assign illegal = illegal_r;
`else
  // Bits [14:13] carry no meaning in the permissive build.
  logic unused_ir_s;
  assign unused_ir_s = ^ir_r[14:13];
`endif

  assign bus.pc        = pc_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = a_r[PC_W-1:0];
  assign bus.mem_wdata = wdr_r;
  assign a_reg         = a_r;
  assign d_reg         = d_r;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;
  import hack_pkg::*;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] data;
    int          hold;
  } mem_exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] a_reg, d_reg;
`ifdef HACK_CPU_STRICT_EN
  logic illegal;
`endif

  always #5 clk = ~clk;

  hack_cpu_ctrl_if bus ();

  hack_cpu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .a_reg (a_reg),
    .d_reg (d_reg)
`ifdef HACK_CPU_STRICT_EN
    , .illegal (illegal)
`endif
  );

  logic [15:0] rom [0:31];
  int          rom_len;
  int          ack_delay;
  logic [15:0] rd_data;
  mem_exp_t    exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Zero-wait ROM. Fetches past rom_len stall the core in FETCH.
  assign bus.instr       = rom[bus.pc[4:0]];
  assign bus.instr_valid = (int'(bus.pc) < rom_len);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic we, input logic [14:0] addr, input logic [15:0] data, input int hold);
    mem_exp_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    e.hold = hold;
    exp_q.push_back(e);
  endtask

  task automatic wait_pc(input string tag, input logic [14:0] target, input int budget);
    int n = 0;
    while (bus.pc !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.pc, target);
  endtask

  task automatic wait_req(input string tag, input logic we, input int budget);
    int n = 0;
    while (!(bus.mem_req === 1'b1 && bus.mem_we === we) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {bus.mem_req, bus.mem_we}, {1'b1, we});
  endtask

  // Data memory: acks after ack_delay wait cycles, scoreboard pop per ack.
  initial begin
    int hold;
    mem_exp_t e;
    hold = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset || !bus.mem_req) begin
        hold = 0;
        bus.mem_ack = 1'b0;
      end else if (!bus.mem_ack) begin
        hold++;
        if (hold > ack_delay) begin
          if (exp_q.size() == 0) begin
            check("unexpected_req", {31'd0, bus.mem_req}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
            check("mem_addr", {17'd0, bus.mem_addr}, {17'd0, e.addr});
            if (e.we) check("mem_wdata", {16'd0, bus.mem_wdata}, {16'd0, e.data});
            check("req_hold", hold, e.hold);
          end
          bus.mem_rdata = rd_data;
          bus.mem_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    logic [15:0] d_plus_a;
    logic [15:0] d_zero;
    d_plus_a = {3'b111, 1'b0, COMP_D_PLUS_A, 3'b010, 3'b000};  // D=D+A
    d_zero   = {3'b111, 1'b0, COMP_ZERO, 3'b010, 3'b000};      // D=0
    reset = 1'b1;
    rom_len = 0;
    ack_delay = 0;
    rd_data = 16'h0000;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    repeat (3) @(negedge clk);

    check("rst_pc", bus.pc, 32'd0);
    check("rst_a", a_reg, 32'd0);
    check("rst_d", d_reg, 32'd0);
    check("rst_req", bus.mem_req, 32'd0);
    check("rst_we", bus.mem_we, 32'd0);

    // @17; D=A; @6; D=D+A
    rom[0] = 16'h0011;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0006;
    rom[3] = d_plus_a;
    rom_len = 4;
    reset = 1'b0;
    n = 0;
    while (bus.pc !== 15'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a_instr_cycles", n, 2);
    wait_pc("pc_after_add", 15'd4, 50);
    check("d_after_add", d_reg, 32'd23);
    check("a_after_add", a_reg, 32'd6);

    // @100; M=D with three wait cycles
    rom[4] = 16'h0064;
    rom[5] = 16'hE308;
    ack_delay = 3;
    push_exp(1'b1, 15'd100, 16'd23, 4);
    rom_len = 6;
    wait_req("mem_wr_entered", 1'b1, 50);
    check("pc_held_in_wr", bus.pc, 32'd5);
    check("d_in_wr", d_reg, 32'd23);
    wait_pc("pc_after_wr", 15'd6, 50);
    check("d_after_wr", d_reg, 32'd23);
    check("a_after_wr", a_reg, 32'd100);

    // @10; D;JGT with D=23 jumps
    rom[6] = 16'h000A;
    rom[7] = 16'hE301;
    rom_len = 8;
    wait_pc("jgt_taken", 15'd10, 50);

    // D=0; @10; D;JGT falls through
    rom[10] = d_zero;
    rom[11] = 16'h000A;
    rom[12] = 16'hE301;
    rom_len = 13;
    wait_pc("jgt_not_taken", 15'd13, 50);
    check("d_zero", d_reg, 32'd0);
    check("a_ten", a_reg, 32'd10);

    // @100; D=M with read data 0xFFFF
    rom[13] = 16'h0064;
    rom[14] = 16'hFC10;
    rd_data = 16'hFFFF;
    ack_delay = 1;
    push_exp(1'b0, 15'd100, 16'h0000, 2);
    rom_len = 15;
    wait_req("mem_rd_entered", 1'b0, 50);
    wait_pc("pc_after_rd", 15'd15, 50);
    check("d_after_rd", d_reg, 32'h0000FFFF);
    check("a_after_rd", a_reg, 32'd100);

    // M=D, then reset before the ack arrives
    rom[15] = 16'hE308;
    ack_delay = 1000;
    rom_len = 16;
    wait_req("mem_wr_pending", 1'b1, 50);
    #2;
    reset = 1'b1;
    #1;
    check("async_req_drop", bus.mem_req, 32'd0);
    check("async_we_drop", bus.mem_we, 32'd0);
    check("async_pc", bus.pc, 32'd0);
    check("async_a", a_reg, 32'd0);
    check("async_d", d_reg, 32'd0);
    rom_len = 0;
    rom[0] = 16'h8000;
    rom[1] = d_zero;
    ack_delay = 0;
    repeat (2) @(negedge clk);

    // 0x8000 from the first post-reset fetch at pc=0
    rom_len = 2;
    reset = 1'b0;
`ifdef HACK_CPU_STRICT_EN
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("halt_pc", bus.pc, 32'd0);
      check("illegal", illegal, 32'd1);
      check("halt_req", bus.mem_req, 32'd0);
      @(negedge clk);
    end
`else
    rom_len = 1;
    wait_pc("and_no_dest_pc", 15'd1, 50);
    check("and_no_dest_a", a_reg, 32'd0);
    check("and_no_dest_d", d_reg, 32'd0);
`endif
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack CPU core that drives the existing `alu` block.
- Generates the six ALU control bits (zx, nx, zy, ny, f, no) from the C-instruction comp field.
- Consumes the ALU's zr/ng flags for jump resolution.
- Owns the A, D and PC registers; talks to instruction ROM and data RAM through valid/ack handshakes.

Parameters:
- W, 16, datapath width; fixed to the Hack word.
- PC_W, 15, program-counter / address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  out  PC_W  instruction fetch address.
- instr  in  W  instruction word from ROM.
- instr_valid  in  1  instr holds the word for the current pc.
- mem_req  out  1  data-memory request.
- mem_we  out  1  write strobe; qualified by mem_req.
- mem_addr  out  PC_W  data address (A[14:0]).
- mem_wdata  out  W  write data (ALU result).
- mem_rdata  in  W  read data; valid when mem_ack=1.
- mem_ack  in  1  memory has completed the request.
- a_reg  out  W  A register (observability).
- d_reg  out  W  D register (observability).

Behaviour:
- Reset (async): pc=0, A=0, D=0, IR=0, mem_req=0, mem_we=0, state=FETCH. Reset mid-transaction drops mem_req immediately; no write completes.
- FETCH: pc is stable. On the first edge with instr_valid=1, IR<=instr and state goes to DECODE.
- DECODE:
  - IR[15]=0 (A-instruction): A<=IR, pc<=pc+1, next FETCH. Total 2 cycles with zero ROM wait.
  - IR[15]=1 and a-bit IR[12]=1: next MEM_RD.
  - Otherwise: next EXEC.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr=A[14:0].
  - On mem_ack: MDR<=mem_rdata, next EXEC.
  - mem_req holds high until ack.
- EXEC:
  - ALU x=D, y = a-bit ? MDR : A.
  - Controls: zx=IR[11], nx=IR[10], zy=IR[9], ny=IR[8], f=IR[7], no=IR[6].
  - Jump: jmp = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - d3=IR[3] set: latch ALU result into WDR, next MEM_WR. A/D/PC update is deferred to the MEM_WR ack edge.
  - d3 clear: commit now, next FETCH.
- Commit rules:
  - Jump target and write address always use the pre-instruction A value.
  - If d1: A<=result. If d2: D<=result.
  - pc <= jmp ? A_old[14:0] : pc+1.
- MEM_WR:
  - mem_req=1, mem_we=1, mem_addr=A_old, mem_wdata=WDR.
  - Held until mem_ack, then commit, next FETCH.
- Arithmetic: ALU adds modulo 2^16. pc+1 wraps 0x7FFF→0x0000.
- mem_ack outside MEM_RD/MEM_WR is ignored. instr_valid outside FETCH is ignored.
- States are FETCH, DECODE, MEM_RD, EXEC, MEM_WR, plus HALT when the optional feature below is enabled.

Optional Feature:
- Macro: HACK_CPU_STRICT_EN.
- Defined:
  - A C-instruction with IR[14:13]≠2'b11 enters HALT.
  - HALT: pc frozen, mem_req=0, registers unchanged; exit only by reset.
  - Adds output port `illegal` (1 bit), high while in HALT.
- Undefined: IR[14:13] ignored, no HALT state, no `illegal` port.

Decomposition:
- Package hack_pkg:
  - State enum.
  - Instruction field bit positions (A_BIT=12, comp 11:6, dest 5:3, jump 2:0).
  - Opcode constants, e.g. COMP_D_PLUS_A=6'b000010, COMP_ZERO=6'b101010.
- Sub-module: instantiate the existing `alu` unchanged. The controller supplies only x, y and the control bits.

Test Plan:
- ROM sequence 0x0011, 0xEC10, 0x0006, 0xE090 (@17; D=A; @6; D=D+A), zero wait → D=23, A=6, pc=4; the A-instruction takes 2 cycles.
- Continue with 0x0064, 0xE308 (@100; M=D), mem_ack delayed 3 cycles → mem_req/mem_we held 4 cycles, mem_addr=100, mem_wdata=23; D unchanged; pc advances only after ack.
- With D=23: 0x000A, 0xE301 (@10; D;JGT) → pc=10. Repeat with D=0 → pc=next sequential address (no jump).
- 0x0064, 0xFC10 (@100; D=M), mem_rdata=0xFFFF on ack → D=0xFFFF; MEM_RD state entered.
- Assert reset while in MEM_WR before ack → mem_req falls without a clock edge; pc=A=D=0; first post-reset fetch is at pc=0.
- HACK_CPU_STRICT_EN defined, feed 0x8000 → illegal=1, pc frozen for 10 cycles. Undefined: 0x8000 executes as D&A with no destination, pc+1.
